// File: rtl/feed_packet_assembler.sv
// -----------------------------------------------------------------------------
// feed_packet_assembler
//
// Frames a 32-bit feed word stream into 4-word (128-bit) market-data packets.
// Each frame is checked for sync byte, exact length and inter-word idle gaps.
// Good frames are emitted as a one-cycle valid pulse; malformed frames are
// dropped, counted and recorded in sticky error flags.
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous active-high reset
//   word_in          feed word
//   word_in_valid    word_in valid this cycle (always accepted)
//   word_in_last     final word of a frame, qualified by word_in_valid
//   packet_out       assembled packet, word0 in [31:0] ... word3 in [127:96]
//   packet_out_valid one-cycle pulse when packet_out is updated
//   pkt_count        good packets emitted (saturating)
//   drop_count       frames dropped for any reason (saturating)
//   err_sync         sticky: a frame failed the sync check
//   err_len          sticky: a frame was short or long
//   err_timeout      sticky: a frame timed out
// -----------------------------------------------------------------------------
module feed_packet_assembler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      word_in,
  input  logic             word_in_valid,
  input  logic             word_in_last,
  output logic [127:0]     packet_out,
  output logic             packet_out_valid,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             err_sync,
  output logic             err_len,
  output logic             err_timeout
);

  // Idle counter only needs to reach TIMEOUT_CYCLES-1 before expiry fires.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISCARD
  } state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [TW-1:0]    r_tmo;
  logic [31:0]      r_slot [0:2];
  logic [127:0]     r_packet_out;
  logic             r_packet_out_valid;
  logic [CNT_W-1:0] r_pkt_count;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_err_sync;
  logic             r_err_len;
  logic             r_err_timeout;

  logic       w_sync_ok;
  logic       w_tmo_expire;
  logic       w_commit;
  logic       w_drop;
  logic       w_set_sync;
  logic       w_set_len;
  logic       w_set_tmo;
  logic [2:0] w_slot_we;

  assign w_sync_ok = (word_in[31:24] == SYNC_BYTE);

  // Expiry is the cycle in which the idle count would reach TIMEOUT_CYCLES.
  // A valid word in that same cycle takes priority (checked in the decode).
  assign w_tmo_expire = (TIMEOUT_CYCLES != 0) &&
                        (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // Event decode: what happens to the frame on this cycle.
  always_comb begin
    w_commit   = 1'b0;
    w_drop     = 1'b0;
    w_set_sync = 1'b0;
    w_set_len  = 1'b0;
    w_set_tmo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (word_in_valid) begin
          if (!w_sync_ok) begin
            w_set_sync = 1'b1;
            w_drop     = 1'b1;
          end else if (word_in_last) begin
            w_set_len = 1'b1;
            w_drop    = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (word_in_valid) begin
          if (r_idx == 2'd3) begin
            if (word_in_last) begin
              w_commit = 1'b1;
            end else begin
              w_set_len = 1'b1;
              w_drop    = 1'b1;
            end
          end else if (word_in_last) begin
            w_set_len = 1'b1;
            w_drop    = 1'b1;
          end
        end else if (w_tmo_expire) begin
          w_set_tmo = 1'b1;
          w_drop    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Slots 0..2 hold the first three words; word 3 goes straight into
  // packet_out on commit so the pulse lands one cycle after the last word.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      if (gi == 0) begin : g_first
        assign w_slot_we[gi] = (r_state == S_IDLE) && word_in_valid &&
                               w_sync_ok && !word_in_last;
      end else begin : g_rest
        assign w_slot_we[gi] = (r_state == S_COLLECT) && word_in_valid &&
                               (r_idx == 2'(gi));
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_slot[gi] <= '0;
        end else if (w_slot_we[gi]) begin
          r_slot[gi] <= word_in;
        end
      end
    end
  endgenerate

  // Frame state machine with registered outputs, counters and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_idx              <= '0;
      r_tmo              <= '0;
      r_packet_out       <= '0;
      r_packet_out_valid <= 1'b0;
      r_pkt_count        <= '0;
      r_drop_count       <= '0;
      r_err_sync         <= 1'b0;
      r_err_len          <= 1'b0;
      r_err_timeout      <= 1'b0;
    end else begin
      r_packet_out_valid <= w_commit;
      if (w_commit) begin
        r_packet_out <= {word_in, r_slot[2], r_slot[1], r_slot[0]};
      end

      if (w_commit && (r_pkt_count != '1)) begin
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end

      if (w_set_sync) r_err_sync    <= 1'b1;
      if (w_set_len)  r_err_len     <= 1'b1;
      if (w_set_tmo)  r_err_timeout <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          r_idx <= '0;
          if (word_in_valid && !word_in_last) begin
            if (w_sync_ok) begin
              r_idx   <= 2'd1;
              r_state <= S_COLLECT;
            end else begin
              r_state <= S_DISCARD;
            end
          end
        end
        S_COLLECT: begin
          if (word_in_valid) begin
            r_tmo <= '0;
            if (word_in_last) begin
              r_state <= S_IDLE;
            end else if (r_idx == 2'd3) begin
              r_state <= S_DISCARD;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_tmo_expire) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_DISCARD: begin
          r_tmo <= '0;
          if (word_in_valid && word_in_last) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign packet_out       = r_packet_out;
  assign packet_out_valid = r_packet_out_valid;
  assign pkt_count        = r_pkt_count;
  assign drop_count       = r_drop_count;
  assign err_sync         = r_err_sync;
  assign err_len          = r_err_len;
  assign err_timeout      = r_err_timeout;

endmodule

// File: tb/tb_feed_packet_assembler.sv
// Bench for feed_packet_assembler. Frames are generated as whole word lists;
// the reference model classifies each frame (good / bad sync / bad length /
// timed out) and pushes expected packets with their expected arrival cycle.
// A negedge monitor pops and compares whenever a packet pulse appears.
// A second instance with 3-bit counters shares the stimulus so counter
// saturation is exercised.
module tb_feed_packet_assembler;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  word_in;
  logic         word_in_valid;
  logic         word_in_last;
  logic [127:0] packet_out, packet_out_s;
  logic         packet_out_valid, packet_out_valid_s;
  logic [15:0]  pkt_count, drop_count;
  logic [2:0]   pkt_count_s, drop_count_s;
  logic         err_sync, err_len, err_timeout;
  logic         err_sync_s, err_len_s, err_timeout_s;

  feed_packet_assembler #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_in_valid(word_in_valid),
    .word_in_last(word_in_last), .packet_out(packet_out),
    .packet_out_valid(packet_out_valid), .pkt_count(pkt_count),
    .drop_count(drop_count), .err_sync(err_sync), .err_len(err_len),
    .err_timeout(err_timeout));

  feed_packet_assembler #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .word_in(word_in), .word_in_valid(word_in_valid),
    .word_in_last(word_in_last), .packet_out(packet_out_s),
    .packet_out_valid(packet_out_valid_s), .pkt_count(pkt_count_s),
    .drop_count(drop_count_s), .err_sync(err_sync_s), .err_len(err_len_s),
    .err_timeout(err_timeout_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [127:0] data;
    int           cycle;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [127:0] hold_val = '0;

  // reference model state
  int m_pkt, m_drop;
  bit m_sync, m_len, m_tmo;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      check("small_valid", 128'(packet_out_valid_s), 128'(packet_out_valid));
      if (packet_out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got %0h expected no pulse (cycle %0d)", packet_out, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("packet_data", packet_out, e.data);
          check("packet_cycle", 128'(cyc), 128'(e.cycle));
          check("small_packet", packet_out_s, e.data);
          hold_val = e.data;
        end
      end else begin
        check("packet_hold", packet_out, hold_val);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] w, input bit last, output int c);
    word_in       = w;
    word_in_valid = 1'b1;
    word_in_last  = last;
    c             = cyc + 1;
    @(posedge clk);
    #1;
    word_in_valid = 1'b0;
    word_in_last  = $urandom_range(0, 1);  // must be ignored without valid
    word_in       = $urandom;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_pkt"},    128'(pkt_count),    128'(sat(m_pkt, 65535)));
    check({tag, "_drop"},   128'(drop_count),   128'(sat(m_drop, 65535)));
    check({tag, "_pkt_s"},  128'(pkt_count_s),  128'(sat(m_pkt, 7)));
    check({tag, "_drop_s"}, 128'(drop_count_s), 128'(sat(m_drop, 7)));
    check({tag, "_esync"},  128'(err_sync),     128'(m_sync));
    check({tag, "_elen"},   128'(err_len),      128'(m_len));
    check({tag, "_etmo"},   128'(err_timeout),  128'(m_tmo));
  endtask

  // Send a frame; gap = idle cycles between words (-1 = random 0..T-1).
  // truncate: no last flag, frame abandoned and left to time out.
  task automatic send_frame(input logic [31:0] ws[$], input int gap, input bit truncate);
    int  c;
    int  n;
    bit  good;
    n    = ws.size();
    good = (ws[0][31:24] == 8'hA5);
    for (int i = 0; i < n; i++) begin
      send(ws[i], (i == n - 1) && !truncate, c);
      if (i < n - 1) idle((gap < 0) ? $urandom_range(0, T - 1) : gap);
    end
    if (truncate) begin
      idle(T - 1);
      check("pre_timeout_drop", 128'(drop_count), 128'(sat(m_drop, 65535)));
      idle(1);
      m_drop++;
      m_tmo = 1'b1;
    end else if (!good) begin
      m_drop++;
      m_sync = 1'b1;
    end else if (n != 4) begin
      m_drop++;
      m_len = 1'b1;
    end else begin
      exp_t e;
      e.data  = {ws[3], ws[2], ws[1], ws[0]};
      e.cycle = c;
      sb.push_back(e);
      m_pkt++;
    end
    check_status("frame");
  endtask

  function automatic logic [31:0] rand_word0(input bit good);
    logic [7:0] b;
    if (good) return {8'hA5, 24'($urandom)};
    b = 8'($urandom_range(0, 254));
    if (b >= 8'hA5) b = b + 8'd1;
    return {b, 24'($urandom)};
  endfunction

  function automatic void make_words(input int n, input bit good, output logic [31:0] q[$]);
    q = {};
    q.push_back(rand_word0(good));
    for (int i = 1; i < n; i++) q.push_back($urandom);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    hold_val = '0;
    m_pkt = 0; m_drop = 0; m_sync = 0; m_len = 0; m_tmo = 0;
  endtask

  initial begin
    logic [31:0] q[$];
    int          c;
    reset         = 1'b1;
    word_in       = '0;
    word_in_valid = 1'b0;
    word_in_last  = 1'b0;
    m_pkt = 0; m_drop = 0; m_sync = 0; m_len = 0; m_tmo = 0;
    idle(3);
    reset = 1'b0;
    check("reset_packet", packet_out, 128'h0);
    check("reset_valid", 128'(packet_out_valid), 128'h0);
    check_status("reset");

    // directed good frame
    send_frame('{32'hA5000001, 32'h00000002, 32'h00000003, 32'h00000004}, 0, 0);
    check("fixed_packet", packet_out, 128'h00000004_00000003_00000002_A5000001);

    // two back-to-back frames, then one with 3-cycle gaps
    make_words(4, 1, q); send_frame(q, 0, 0);
    make_words(4, 1, q); send_frame(q, 0, 0);
    make_words(4, 1, q); send_frame(q, 3, 0);

    // bad sync then good frame
    send_frame('{32'h5A000000, 32'h1, 32'h2, 32'h3}, 0, 0);
    make_words(4, 1, q); send_frame(q, 0, 0);

    // short, long, then good
    make_words(2, 1, q); send_frame(q, 0, 0);
    make_words(6, 1, q); send_frame(q, 1, 0);
    make_words(4, 1, q); send_frame(q, 0, 0);

    // timeout, and a word exactly on the last allowed idle cycle
    make_words(2, 1, q); send_frame(q, 0, 1);
    make_words(4, 1, q); send_frame(q, T - 1, 0);
    make_words(4, 1, q); send_frame(q, 0, 0);

    // reset in the middle of a frame
    make_words(4, 1, q);
    for (int i = 0; i < 3; i++) send(q[i], 1'b0, c);
    do_reset();
    check("midreset_packet", packet_out, 128'h0);
    check_status("midreset");
    make_words(4, 1, q); send_frame(q, 0, 0);

    // randomized frames
    for (int f = 0; f < 250; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        make_words(4, 1, q);
        send_frame(q, ($urandom_range(0, 3) == 0) ? -1 : 0, 0);
      end else if (kind == 5) begin
        make_words($urandom_range(1, 6), 0, q);
        send_frame(q, $urandom_range(0, 2), 0);
      end else if (kind == 6) begin
        make_words($urandom_range(1, 3), 1, q);
        send_frame(q, $urandom_range(0, 2), 0);
      end else if (kind == 7) begin
        make_words($urandom_range(5, 7), 1, q);
        send_frame(q, $urandom_range(0, 2), 0);
      end else begin
        make_words($urandom_range(1, 3), 1, q);
        send_frame(q, $urandom_range(0, 2), 1);
      end
      idle($urandom_range(0, 2));
    end

    idle(4);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_packets: got %0d outstanding expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
